// File: rtl/x3q16_memory.sv
// x3q16 request-bus memory responder with programmable read/write latency.
// Optional write protection of the low address window: X3Q16_MEM_WRITE_PROTECT_EN.
module x3q16_memory #(
   parameter int          ADDR_BITS     = 10,
   parameter int          READ_LATENCY  = 2,
   parameter int          WRITE_LATENCY = 1,
   parameter logic [15:0] PROTECT_TOP   = 16'h0040
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        request,
   input  logic        request_type,
   input  logic [15:0] request_address,
   input  logic [15:0] data_in,
   output logic [15:0] memory_in,
   output logic        memory_ready,
   output logic        write_complete,
   output logic        memory_critical,
   output logic        busy
);

   localparam int         DEPTH   = 1 << ADDR_BITS;
   localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
   localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);
`ifdef X3Q16_MEM_WRITE_PROTECT_EN
   localparam bit PROTECT_EN = 1'b1;
`else
   localparam bit PROTECT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

   state_t      state, state_next;
   logic [3:0]  cnt, cnt_next;
   logic [15:0] addr, addr_next;
   logic [15:0] wdata, wdata_next;
   logic [15:0] memory_in_next;
   logic        ready_next, complete_next, critical_next;
   logic        in_range, write_blocked, commit;
   logic [15:0] rd_word;
   logic [15:0] mem [0:DEPTH-1];

   assign in_range      = (addr >> ADDR_BITS) == 16'd0;
   assign write_blocked = PROTECT_EN && (addr < PROTECT_TOP);
   assign rd_word       = in_range ? mem[addr[ADDR_BITS-1:0]] : 16'h0000;
   assign busy          = (state != IDLE);

   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      addr_next      = addr;
      wdata_next     = wdata;
      memory_in_next = memory_in;
      ready_next     = 1'b0;
      complete_next  = 1'b0;
      critical_next  = 1'b0;
      commit         = 1'b0;
      case (state)
         IDLE: begin
            if (request) begin
               addr_next  = request_address;
               wdata_next = data_in;
               if (request_type) begin
                  state_next = WR_WAIT;
                  cnt_next   = WR_LOAD;
               end else begin
                  state_next = RD_WAIT;
                  cnt_next   = RD_LOAD;
               end
            end
         end
         RD_WAIT: begin
            // A request arriving while busy is dropped and flagged.
            critical_next = request;
            if (cnt == 4'd0) begin
               memory_in_next = rd_word;
               ready_next     = 1'b1;
               critical_next  = request || !in_range;
               state_next     = IDLE;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         WR_WAIT: begin
            critical_next = request;
            if (cnt == 4'd0) begin
               commit        = in_range && !write_blocked;
               complete_next = 1'b1;
               critical_next = request || !in_range || write_blocked;
               state_next    = IDLE;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         cnt             <= 4'd0;
         memory_in       <= 16'h0000;
         memory_ready    <= 1'b0;
         write_complete  <= 1'b0;
         memory_critical <= 1'b0;
      end else begin
         state           <= state_next;
         cnt             <= cnt_next;
         memory_in       <= memory_in_next;
         memory_ready    <= ready_next;
         write_complete  <= complete_next;
         memory_critical <= critical_next;
      end
   end

   // Latched request fields carry no reset; they are only used while busy.
   always_ff @(posedge clk) begin
      addr  <= addr_next;
      wdata <= wdata_next;
   end

   always_ff @(posedge clk) begin
      if (commit) mem[addr[ADDR_BITS-1:0]] <= wdata;
   end

endmodule

// File: tb/tb_x3q16_memory.sv
// Directed bench for x3q16_memory: one instance at default latencies (2/1),
// one at read 3 / write 4. Inputs change and outputs are sampled at negedge.
module tb_x3q16_memory;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_a = 1'b0, type_a = 1'b0;
   logic [15:0] addr_a = '0, din_a = '0;
   logic [15:0] mem_a;
   logic        rdy_a, wc_a, crit_a, busy_a;
   logic        req_b = 1'b0, type_b = 1'b0;
   logic [15:0] addr_b = '0, din_b = '0;
   logic [15:0] mem_b;
   logic        rdy_b, wc_b, crit_b, busy_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   x3q16_memory dut_a (
      .clk(clk), .reset(reset), .request(req_a), .request_type(type_a),
      .request_address(addr_a), .data_in(din_a), .memory_in(mem_a),
      .memory_ready(rdy_a), .write_complete(wc_a), .memory_critical(crit_a),
      .busy(busy_a)
   );

   x3q16_memory #(.READ_LATENCY(3), .WRITE_LATENCY(4)) dut_b (
      .clk(clk), .reset(reset), .request(req_b), .request_type(type_b),
      .request_address(addr_b), .data_in(din_b), .memory_in(mem_b),
      .memory_ready(rdy_b), .write_complete(wc_b), .memory_critical(crit_b),
      .busy(busy_b)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Request is presented for one cycle; returns at the negedge after it was sampled.
   task automatic issue_a(input logic t, input logic [15:0] a, input logic [15:0] d);
      req_a = 1'b1; type_a = t; addr_a = a; din_a = d;
      @(negedge clk);
      req_a = 1'b0;
   endtask

   task automatic issue_b(input logic t, input logic [15:0] a, input logic [15:0] d);
      req_b = 1'b1; type_b = t; addr_b = a; din_b = d;
      @(negedge clk);
      req_b = 1'b0;
   endtask

   initial begin
      tick(); tick();
      chk("rst_mem_in", mem_a, 16'h0000);
      chk("rst_ready", {15'd0, rdy_a}, 16'd0);
      chk("rst_wc", {15'd0, wc_a}, 16'd0);
      chk("rst_crit", {15'd0, crit_a}, 16'd0);
      chk("rst_busy", {15'd0, busy_a}, 16'd0);
      reset = 1'b0;
      tick();

      // Write then read, latency 2/1
      issue_a(1'b1, 16'h0100, 16'hBEEF);
      chk("wr_busy", {15'd0, busy_a}, 16'd1);
      chk("wr_wc_early", {15'd0, wc_a}, 16'd0);
      tick();
      chk("wr_wc", {15'd0, wc_a}, 16'd1);
      chk("wr_crit", {15'd0, crit_a}, 16'd0);
      chk("wr_busy_done", {15'd0, busy_a}, 16'd0);
      tick();
      chk("wr_wc_width", {15'd0, wc_a}, 16'd0);
      issue_a(1'b0, 16'h0100, 16'h0000);
      chk("rd_rdy_n0", {15'd0, rdy_a}, 16'd0);
      tick();
      chk("rd_rdy_n1", {15'd0, rdy_a}, 16'd0);
      tick();
      chk("rd_rdy_n2", {15'd0, rdy_a}, 16'd1);
      chk("rd_data", mem_a, 16'hBEEF);
      chk("rd_crit", {15'd0, crit_a}, 16'd0);
      tick();
      chk("rd_rdy_width", {15'd0, rdy_a}, 16'd0);
      chk("rd_data_hold", mem_a, 16'hBEEF);

      // Back-to-back: read accepted at the edge after the write response
      issue_a(1'b1, 16'h0101, 16'hCAFE);
      tick();
      chk("b2b_wc", {15'd0, wc_a}, 16'd1);
      issue_a(1'b0, 16'h0101, 16'h0000);
      chk("b2b_busy", {15'd0, busy_a}, 16'd1);
      chk("b2b_crit", {15'd0, crit_a}, 16'd0);
      tick(); tick();
      chk("b2b_rdy", {15'd0, rdy_a}, 16'd1);
      chk("b2b_data", mem_a, 16'hCAFE);

      // Out-of-range accesses
      issue_a(1'b1, 16'h0000, 16'h1111);
      tick();
      issue_a(1'b1, 16'h0400, 16'hAAAA);
      tick();
      chk("oor_wc", {15'd0, wc_a}, 16'd1);
      chk("oor_wr_crit", {15'd0, crit_a}, 16'd1);
      issue_a(1'b0, 16'h0400, 16'h0000);
      chk("oor_crit_clear", {15'd0, crit_a}, 16'd0);
      tick(); tick();
      chk("oor_rdy", {15'd0, rdy_a}, 16'd1);
      chk("oor_rd_data", mem_a, 16'h0000);
      chk("oor_rd_crit", {15'd0, crit_a}, 16'd1);
      tick();
      issue_a(1'b0, 16'h0000, 16'h0000);
      tick(); tick();
      chk("oor_mem0", mem_a, 16'h1111);
      chk("oor_mem0_crit", {15'd0, crit_a}, 16'd0);

      // Write protect window
      tick();
      issue_a(1'b1, 16'h0010, 16'h1234);
      tick();
      chk("wp_wc", {15'd0, wc_a}, 16'd1);
`ifdef X3Q16_MEM_WRITE_PROTECT_EN
      chk("wp_crit", {15'd0, crit_a}, 16'd1);
`else
      chk("wp_crit", {15'd0, crit_a}, 16'd0);
`endif
      issue_a(1'b0, 16'h0010, 16'h0000);
      tick(); tick();
      chk("wp_rdy", {15'd0, rdy_a}, 16'd1);
`ifdef X3Q16_MEM_WRITE_PROTECT_EN
      chk("wp_not_written", {15'd0, mem_a === 16'h1234}, 16'd0);
`else
      chk("wp_data", mem_a, 16'h1234);
`endif

      // Latency sweep on instance b (read 3, write 4)
      tick();
      issue_b(1'b1, 16'h0020, 16'h7777);
      chk("lat_wr_busy0", {15'd0, busy_b}, 16'd1);
      tick(); tick(); tick();
      chk("lat_wr_wc3", {15'd0, wc_b}, 16'd0);
      chk("lat_wr_busy3", {15'd0, busy_b}, 16'd1);
      tick();
      chk("lat_wr_wc4", {15'd0, wc_b}, 16'd1);
      chk("lat_wr_busy4", {15'd0, busy_b}, 16'd0);
      tick();
      chk("lat_wr_wc5", {15'd0, wc_b}, 16'd0);
      issue_b(1'b0, 16'h0020, 16'h0000);
      tick();
      tick();
      chk("lat_rd_rdy2", {15'd0, rdy_b}, 16'd0);
      chk("lat_rd_busy2", {15'd0, busy_b}, 16'd1);
      tick();
      chk("lat_rd_rdy3", {15'd0, rdy_b}, 16'd1);
      chk("lat_rd_data", mem_b, 16'h7777);
      chk("lat_rd_busy3", {15'd0, busy_b}, 16'd0);
      tick();
      chk("lat_rd_rdy4", {15'd0, rdy_b}, 16'd0);

      // Request while busy on instance b
      issue_b(1'b1, 16'h0030, 16'h3333);
      tick(); tick(); tick(); tick();
      issue_b(1'b0, 16'h0020, 16'h0000);
      issue_b(1'b0, 16'h0030, 16'h0000);
      chk("drop_crit", {15'd0, crit_b}, 16'd1);
      tick();
      chk("drop_crit_once", {15'd0, crit_b}, 16'd0);
      chk("drop_rdy2", {15'd0, rdy_b}, 16'd0);
      tick();
      chk("drop_rdy3", {15'd0, rdy_b}, 16'd1);
      chk("drop_data", mem_b, 16'h7777);
      chk("drop_crit3", {15'd0, crit_b}, 16'd0);
      tick();
      chk("drop_rdy4", {15'd0, rdy_b}, 16'd0);
      tick();
      chk("drop_rdy5", {15'd0, rdy_b}, 16'd0);
      chk("drop_busy5", {15'd0, busy_b}, 16'd0);

      // Reset mid-read on instance a
      issue_a(1'b0, 16'h0100, 16'h0000);
      reset = 1'b1;
      tick();
      chk("mrst_rdy", {15'd0, rdy_a}, 16'd0);
      chk("mrst_busy", {15'd0, busy_a}, 16'd0);
      chk("mrst_mem_in", mem_a, 16'h0000);
      tick();
      chk("mrst_rdy2", {15'd0, rdy_a}, 16'd0);
      chk("mrst_crit", {15'd0, crit_a}, 16'd0);
      reset = 1'b0;
      tick();
      chk("mrst_rdy3", {15'd0, rdy_a}, 16'd0);
      issue_a(1'b0, 16'h0100, 16'h0000);
      tick(); tick();
      chk("mrst_ram_kept", mem_a, 16'hBEEF);
      chk("mrst_rdy_after", {15'd0, rdy_a}, 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
